// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared types and constants for the nibble-serial multiplier
package mul_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;
  localparam int PP_W  = 8;

  // One CALC cycle per nibble pair.
  function automatic int num_steps(input int opw);
    return (opw / NIB_W) * (opw / NIB_W);
  endfunction

endpackage

// File: rtl/nibble_mul4x4.sv
// rtl/nibble_mul4x4.sv - combinational 4x4 unsigned AND/full-adder array multiplier
module nibble_mul4x4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);

  logic [3:0] w_pp  [4];
  logic [4:0] w_row [4];

  // Row j adds partial product j onto the upper bits of row j-1; each row retires one LSB.
  always_comb begin
    logic       w_carry;
    logic [3:0] w_addend;
    for (int j = 0; j < 4; j++) begin
      w_pp[j] = i_a & {4{i_b[j]}};
    end
    w_row[0] = {1'b0, w_pp[0]};
    for (int j = 1; j < 4; j++) begin
      w_carry  = 1'b0;
      w_addend = w_row[j-1][4:1];
      for (int k = 0; k < 4; k++) begin
        w_row[j][k] = w_addend[k] ^ w_pp[j][k] ^ w_carry;
        w_carry     = (w_addend[k] & w_pp[j][k]) | (w_carry & (w_addend[k] ^ w_pp[j][k]));
      end
      w_row[j][4] = w_carry;
    end
  end

  assign o_p = {w_row[3], w_row[2][0], w_row[1][0], w_row[0][0]};

endmodule

// File: rtl/mul_nibble_seq.sv
// rtl/mul_nibble_seq.sv - sequential OPW x OPW multiplier sharing one 4x4 array over all nibble pairs
// Optional MUL_ZERO_SKIP_EN: a zero operand skips CALC and goes straight to DONE with p=0.
module mul_nibble_seq
  import mul_seq_pkg::*;
#(
  parameter int OPW = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [OPW-1:0]   i_a,
  input  logic [OPW-1:0]   i_b,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [2*OPW-1:0] o_p,
  output logic             o_busy
);

  localparam int N      = OPW / NIB_W;
  localparam int STEPS  = num_steps(OPW);
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int ACC_W  = 2 * OPW;
  localparam logic [STEP_W-1:0] N_S    = STEP_W'(N);
  localparam logic [STEP_W-1:0] LAST_S = STEP_W'(STEPS - 1);

  state_t            r_state, w_state_nxt;
  logic [OPW-1:0]    r_a, r_b;
  logic [ACC_W-1:0]  r_acc, r_p, w_pp_shift, w_acc_nxt;
  logic [STEP_W-1:0] r_step, w_i, w_j;
  logic [NIB_W-1:0]  w_a_nib, w_b_nib;
  logic [PP_W-1:0]   w_pp;
  logic              w_accept, w_last, w_zero;

  // Step walks a-nibbles fastest: i = step mod N, j = step div N.
  assign w_i        = r_step % N_S;
  assign w_j        = r_step / N_S;
  assign w_a_nib    = NIB_W'(r_a >> (NIB_W * w_i));
  assign w_b_nib    = NIB_W'(r_b >> (NIB_W * w_j));
  assign w_pp_shift = ACC_W'(w_pp) << (NIB_W * (w_i + w_j));
  assign w_acc_nxt  = r_acc + w_pp_shift;
  assign w_last     = (r_step == LAST_S);
  assign w_accept   = i_in_valid && (r_state == ST_IDLE);

`ifdef MUL_ZERO_SKIP_EN
  assign w_zero = (i_a == '0) || (i_b == '0);
`else
  assign w_zero = 1'b0;
`endif

  nibble_mul4x4 u_mul (
    .i_a (w_a_nib),
    .i_b (w_b_nib),
    .o_p (w_pp)
  );

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_state_nxt = w_zero ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        o_busy = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_step  <= '0;
      r_p     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a    <= i_a;
            r_b    <= i_b;
            r_acc  <= '0;
            r_step <= '0;
            if (w_zero) begin
              r_p <= '0;
            end
          end
        end
        ST_CALC: begin
          r_acc <= w_acc_nxt;
          // p only moves on DONE entry so the sink never sees a partial sum.
          if (w_last) begin
            r_p <= w_acc_nxt;
          end else begin
            r_step <= r_step + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_p = r_p;

endmodule

// File: tb/tb_mul_nibble_seq.sv
// tb/tb_mul_nibble_seq.sv - randomized self-checking bench for mul_nibble_seq at OPW=8 and OPW=16
module tb_mul_nibble_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a_bus = '0;
  logic [15:0] b_bus = '0;
  logic        iv8 = 1'b0, ordy8 = 1'b0, ir8, ov8, bz8;
  logic [15:0] p8;
  logic        iv16 = 1'b0, ordy16 = 1'b0, ir16, ov16, bz16;
  logic [31:0] p16;
  int          n_checks = 0;
  int          n_fail   = 0;

`ifdef MUL_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  always #5 clk = ~clk;

  mul_nibble_seq #(.OPW(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(iv8), .o_in_ready(ir8),
    .i_a(a_bus[7:0]), .i_b(b_bus[7:0]), .o_out_valid(ov8),
    .i_out_ready(ordy8), .o_p(p8), .o_busy(bz8)
  );

  mul_nibble_seq #(.OPW(16)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(iv16), .o_in_ready(ir16),
    .i_a(a_bus), .i_b(b_bus), .o_out_valid(ov16),
    .i_out_ready(ordy16), .o_p(p16), .o_busy(bz16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input int w, output logic ov, output logic ir, output logic bz,
                      output logic [31:0] p);
    if (w == 8) begin
      ov = ov8;  ir = ir8;  bz = bz8;  p = {16'h0, p8};
    end else begin
      ov = ov16; ir = ir16; bz = bz16; p = p16;
    end
  endtask

  task automatic drive(input int w, input logic iv, input logic ordy);
    if (w == 8) begin
      iv8 = iv;  ordy8 = ordy;
    end else begin
      iv16 = iv; ordy16 = ordy;
    end
  endtask

  // One full transaction: accept, wait for the product, hold off the sink, drain, check IDLE.
  task automatic op(input string tag, input int w, input logic [15:0] a, input logic [15:0] b,
                    input int hold, input bit glitch);
    logic        ov, ir, bz;
    logic [31:0] p, exp_p;
    int          lat, exp_lat, nn;
    nn      = (w / 4) * (w / 4);
    exp_p   = 32'(a) * 32'(b);
    exp_lat = (ZSKIP && (a == 0 || b == 0)) ? 0 : nn;
    peek(w, ov, ir, bz, p);
    chk({tag, "_ready_idle"}, 32'(ir), 1);
    a_bus = a;
    b_bus = b;
    drive(w, 1'b1, 1'b0);
    tick();
    drive(w, 1'b0, 1'b0);
    a_bus = 16'($urandom);
    b_bus = 16'($urandom);
    lat = 0;
    peek(w, ov, ir, bz, p);
    while (!ov && lat < 64) begin
      chk({tag, "_ready_calc"}, 32'(ir), 0);
      chk({tag, "_busy_calc"}, 32'(bz), 1);
      if (glitch && lat == 1) begin
        a_bus = 16'h0099;
        b_bus = 16'h0077;
        drive(w, 1'b1, 1'b0);
      end else begin
        drive(w, 1'b0, 1'b0);
      end
      tick();
      lat++;
      peek(w, ov, ir, bz, p);
    end
    drive(w, 1'b0, 1'b0);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_valid"}, 32'(ov), 1);
    chk({tag, "_p"}, p, exp_p);
    for (int k = 0; k < hold; k++) begin
      tick();
      peek(w, ov, ir, bz, p);
      chk({tag, "_hold_valid"}, 32'(ov), 1);
      chk({tag, "_hold_p"}, p, exp_p);
    end
    drive(w, 1'b0, 1'b1);
    tick();
    drive(w, 1'b0, 1'b0);
    peek(w, ov, ir, bz, p);
    chk({tag, "_drain_valid"}, 32'(ov), 0);
    chk({tag, "_ready_after_hs"}, 32'(ir), 1);
    chk({tag, "_busy_after_hs"}, 32'(bz), 0);
    chk({tag, "_p_kept"}, p, exp_p);
  endtask

  initial begin
    logic [15:0] ra, rb;
    tick();
    tick();
    chk("rst_ready8", 32'(ir8), 1);
    chk("rst_valid8", 32'(ov8), 0);
    chk("rst_busy8", 32'(bz8), 0);
    chk("rst_p8", 32'(p8), 0);
    chk("rst_ready16", 32'(ir16), 1);
    chk("rst_valid16", 32'(ov16), 0);
    chk("rst_busy16", 32'(bz16), 0);
    chk("rst_p16", p16, 0);
    rst = 1'b0;
    tick();

    op("ff8", 8, 16'h00FF, 16'h00FF, 0, 1'b0);
    op("hold8", 8, 16'h0012, 16'h0034, 5, 1'b0);
    op("glitch8", 8, 16'h0012, 16'h0034, 0, 1'b1);

    // Abort mid-CALC: reset acts immediately, without waiting for a clock edge.
    a_bus = 16'h00AB;
    b_bus = 16'h00CD;
    iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    tick();
    tick();
    chk("abort_busy_before", 32'(bz8), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", 32'(ov8), 0);
    chk("abort_p", 32'(p8), 0);
    chk("abort_ready", 32'(ir8), 1);
    chk("abort_busy", 32'(bz8), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("abort_still_idle", 32'(ov8), 0);
    op("post_abort", 8, 16'h0003, 16'h0005, 0, 1'b0);

    op("zero8", 8, 16'h0000, 16'h00AB, 0, 1'b0);
    op("ff16", 16, 16'hFFFF, 16'hFFFF, 0, 1'b0);
    op("zero16", 16, 16'h1234, 16'h0000, 1, 1'b0);

    for (int n = 0; n < 200; n++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) ra = '0;
      op("rand8", 8, ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 31) == 0) rb = '0;
      op("rand16", 16, ra, rb, $urandom_range(0, 2), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
